// File: rtl/grf_sb_if.sv
// Port bundle of the dual-write register file: read ports, write ports,
// issue port and scoreboard status. Master is the CPU side, slave is grf_sb.
interface grf_sb_if #(
    parameter int DW   = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic          BUSY1;
    logic          BUSY2;
    logic          WE0;
    logic [AW-1:0] A3_0;
    logic [DW-1:0] WD0;
    logic          CLR0;
    logic          WE1;
    logic [AW-1:0] A3_1;
    logic [DW-1:0] WD1;
    logic          CLR1;
    logic          ISS;
    logic [AW-1:0] ISS_A;
    logic [AW:0]   PEND_CNT;

    modport master (
        output A1, A2, WE0, A3_0, WD0, CLR0, WE1, A3_1, WD1, CLR1, ISS, ISS_A,
        input  RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );

    modport slave (
        input  A1, A2, WE0, A3_0, WD0, CLR0, WE1, A3_1, WD1, CLR1, ISS, ISS_A,
        output RD1, RD2, BUSY1, BUSY2, PEND_CNT
    );
endinterface

// File: rtl/grf_sb.sv
// General register file with two combinational read ports, two prioritised
// write ports (port 1 wins) and a per-register pending-write scoreboard.
module grf_sb #(
    parameter int DW     = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1,
    parameter bit TRACE  = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    grf_sb_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    logic [DW-1:0]   r_rf [NREG];
    logic [NREG-1:0] r_pend;
    logic [AW:0]     r_cnt;

    logic            w_we0, w_we1, w_clr0, w_clr1, w_iss;
    logic            w_inc, w_dec0, w_dec1;
    logic [NREG-1:0] w_set_mask, w_clr_mask, w_pend_nxt;

    // Writes and issues to register 0 are discarded before they reach state.
    assign w_we0  = bus.WE0 && (bus.A3_0 != '0);
    assign w_we1  = bus.WE1 && (bus.A3_1 != '0);
    assign w_clr0 = w_we0 && bus.CLR0;
    assign w_clr1 = w_we1 && bus.CLR1;
    assign w_iss  = bus.ISS && (bus.ISS_A != '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_iss)  w_set_mask[bus.ISS_A] = 1'b1;
        if (w_clr0) w_clr_mask[bus.A3_0]  = 1'b1;
        if (w_clr1) w_clr_mask[bus.A3_1]  = 1'b1;
        // Set after clear: a fresh producer supersedes the retiring one.
        w_pend_nxt = (r_pend & ~w_clr_mask) | w_set_mask;
    end

    // Incremental count; a doubly-cleared address is only counted once.
    assign w_inc  = w_iss && !r_pend[bus.ISS_A];
    assign w_dec0 = w_clr0 && r_pend[bus.A3_0] && !(w_iss && bus.ISS_A == bus.A3_0);
    assign w_dec1 = w_clr1 && r_pend[bus.A3_1] && !(w_iss && bus.ISS_A == bus.A3_1)
                    && !(w_clr0 && bus.A3_0 == bus.A3_1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the array is reset explicitly because the CPU relies on a
    // zeroed register file; this costs a reset net on every storage flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_we0) r_rf[bus.A3_0] <= bus.WD0;
            if (w_we1) r_rf[bus.A3_1] <= bus.WD1;
            r_pend <= w_pend_nxt;
            r_cnt  <= r_cnt + {{AW{1'b0}}, w_inc}
                            - {{AW{1'b0}}, w_dec0}
                            - {{AW{1'b0}}, w_dec1};
        end
    end

    logic [AW-1:0] w_ra [2];
    logic [DW-1:0] w_rd [2];
    logic [1:0]    w_busy;

    assign w_ra[0] = bus.A1;
    assign w_ra[1] = bus.A2;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_rd[k]   = '0;
            w_busy[k] = 1'b0;
            if (!reset && w_ra[k] != '0) begin
                w_rd[k]   = r_rf[w_ra[k]];
                w_busy[k] = r_pend[w_ra[k]];
                if (BYPASS) begin
                    if (w_we1 && bus.A3_1 == w_ra[k])      w_rd[k] = bus.WD1;
                    else if (w_we0 && bus.A3_0 == w_ra[k]) w_rd[k] = bus.WD0;
                    if (((w_clr0 && bus.A3_0 == w_ra[k]) || (w_clr1 && bus.A3_1 == w_ra[k]))
                        && !(w_iss && bus.ISS_A == w_ra[k]))
                        w_busy[k] = 1'b0;
                end
            end
        end
    end

    assign bus.RD1      = w_rd[0];
    assign bus.RD2      = w_rd[1];
    assign bus.BUSY1    = w_busy[0];
    assign bus.BUSY2    = w_busy[1];
    assign bus.PEND_CNT = r_cnt;

    generate
        if (TRACE) begin : g_trace
            always @(posedge clk) begin
                if (!reset) begin
                    if (w_we0) $display("%0t@0: $%0d <= 0x%h", $time, bus.A3_0, bus.WD0);
                    if (w_we1) $display("%0t@1: $%0d <= 0x%h", $time, bus.A3_1, bus.WD1);
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb: one bypassing and one non-bypassing instance
// driven by the same stimulus, compared against hand-computed values.
module tb_grf_sb;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] a1, a2, a3_0, a3_1, iss_a;
    logic [DW-1:0] wd0, wd1;
    logic          we0, we1, clr0, clr1, iss;

    int n_vec = 0;
    int n_err = 0;

    grf_sb_if #(.DW(DW), .NREG(NREG)) if_b ();
    grf_sb_if #(.DW(DW), .NREG(NREG)) if_n ();

    assign if_b.A1 = a1;     assign if_n.A1 = a1;
    assign if_b.A2 = a2;     assign if_n.A2 = a2;
    assign if_b.WE0 = we0;   assign if_n.WE0 = we0;
    assign if_b.A3_0 = a3_0; assign if_n.A3_0 = a3_0;
    assign if_b.WD0 = wd0;   assign if_n.WD0 = wd0;
    assign if_b.CLR0 = clr0; assign if_n.CLR0 = clr0;
    assign if_b.WE1 = we1;   assign if_n.WE1 = we1;
    assign if_b.A3_1 = a3_1; assign if_n.A3_1 = a3_1;
    assign if_b.WD1 = wd1;   assign if_n.WD1 = wd1;
    assign if_b.CLR1 = clr1; assign if_n.CLR1 = clr1;
    assign if_b.ISS = iss;   assign if_n.ISS = iss;
    assign if_b.ISS_A = iss_a; assign if_n.ISS_A = iss_a;

    grf_sb #(.DW(DW), .NREG(NREG), .BYPASS(1'b1), .TRACE(1'b1)) u_byp (
        .clk(clk), .reset(reset), .bus(if_b)
    );
    grf_sb #(.DW(DW), .NREG(NREG), .BYPASS(1'b0), .TRACE(1'b0)) u_nob (
        .clk(clk), .reset(reset), .bus(if_n)
    );

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0; iss = 1'b0;
        a3_0 = '0; a3_1 = '0; wd0 = '0; wd1 = '0; iss_a = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); a1 = 5'd0; a2 = 5'd0;
        reset = 1'b1;
        #2;
        n_vec++; if (if_b.RD1 !== 32'h0) begin n_err++; $display("FAIL rst_rd1: got %h want %h", if_b.RD1, 32'h0); end
        n_vec++; if (if_b.PEND_CNT !== 6'd0) begin n_err++; $display("FAIL rst_cnt_b: got %0d want 0", if_b.PEND_CNT); end
        n_vec++; if (if_n.PEND_CNT !== 6'd0) begin n_err++; $display("FAIL rst_cnt_n: got %0d want 0", if_n.PEND_CNT); end
        n_vec++; if (if_b.BUSY1 !== 1'b0) begin n_err++; $display("FAIL rst_busy1: got %b want 0", if_b.BUSY1); end
        step(); step();
        @(negedge clk) reset = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        iss = 1'b1; iss_a = 5'd5; we0 = 1'b1; a3_0 = 5'd5; wd0 = 32'h1234;
        step();
        idle(); a1 = 5'd5;
        #1;
        n_vec++; if (if_n.RD1 !== 32'h1234) begin n_err++; $display("FAIL pre_rd1: got %h want %h", if_n.RD1, 32'h1234); end
        n_vec++; if (if_n.PEND_CNT !== 6'd1) begin n_err++; $display("FAIL pre_cnt: got %0d want 1", if_n.PEND_CNT); end
        n_vec++; if (if_b.BUSY1 !== 1'b1) begin n_err++; $display("FAIL pre_busy1: got %b want 1", if_b.BUSY1); end
        we0 = 1'b1; a3_0 = 5'd5; wd0 = 32'h5678; iss = 1'b1; iss_a = 5'd6;
        #2 reset = 1'b1;
        #1;
        n_vec++; if (if_b.RD1 !== 32'h0) begin n_err++; $display("FAIL mid_rd1_b: got %h want %h", if_b.RD1, 32'h0); end
        n_vec++; if (if_n.RD1 !== 32'h0) begin n_err++; $display("FAIL mid_rd1_n: got %h want %h", if_n.RD1, 32'h0); end
        n_vec++; if (if_b.PEND_CNT !== 6'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", if_b.PEND_CNT); end
        n_vec++; if (if_b.BUSY1 !== 1'b0) begin n_err++; $display("FAIL mid_busy1: got %b want 0", if_b.BUSY1); end
        step();
        @(negedge clk) reset = 1'b0;
        idle(); a2 = 5'd6;
        #1;
        n_vec++; if (if_n.RD1 !== 32'h0) begin n_err++; $display("FAIL post_rd1_n: got %h want %h", if_n.RD1, 32'h0); end
        n_vec++; if (if_b.RD1 !== 32'h0) begin n_err++; $display("FAIL post_rd1_b: got %h want %h", if_b.RD1, 32'h0); end
        n_vec++; if (if_n.PEND_CNT !== 6'd0) begin n_err++; $display("FAIL post_cnt: got %0d want 0", if_n.PEND_CNT); end
        n_vec++; if (if_n.BUSY2 !== 1'b0) begin n_err++; $display("FAIL post_busy2: got %b want 0", if_n.BUSY2); end
    endtask

    task automatic test_collision();
        idle();
        we0 = 1'b1; we1 = 1'b1; a3_0 = 5'd7; a3_1 = 5'd7;
        wd0 = 32'hAAAA_AAAA; wd1 = 32'h5555_5555; a1 = 5'd7;
        #1;
        n_vec++; if (if_b.RD1 !== 32'h5555_5555) begin n_err++; $display("FAIL col_byp_rd1: got %h want %h", if_b.RD1, 32'h5555_5555); end
        n_vec++; if (if_n.RD1 !== 32'h0) begin n_err++; $display("FAIL col_nob_rd1: got %h want %h", if_n.RD1, 32'h0); end
        step();
        idle();
        #1;
        n_vec++; if (if_b.RD1 !== 32'h5555_5555) begin n_err++; $display("FAIL col_rd1_b: got %h want %h", if_b.RD1, 32'h5555_5555); end
        n_vec++; if (if_n.RD1 !== 32'h5555_5555) begin n_err++; $display("FAIL col_rd1_n: got %h want %h", if_n.RD1, 32'h5555_5555); end
    endtask

    task automatic test_zero();
        idle();
        we1 = 1'b1; a3_1 = 5'd0; wd1 = 32'hFFFF_FFFF; iss = 1'b1; iss_a = 5'd0; a1 = 5'd0;
        #1;
        n_vec++; if (if_b.RD1 !== 32'h0) begin n_err++; $display("FAIL zero_rd1_b: got %h want %h", if_b.RD1, 32'h0); end
        n_vec++; if (if_n.RD1 !== 32'h0) begin n_err++; $display("FAIL zero_rd1_n: got %h want %h", if_n.RD1, 32'h0); end
        n_vec++; if (if_b.BUSY1 !== 1'b0) begin n_err++; $display("FAIL zero_busy1: got %b want 0", if_b.BUSY1); end
        step();
        idle();
        #1;
        n_vec++; if (if_b.RD1 !== 32'h0) begin n_err++; $display("FAIL zero_nx_rd1: got %h want %h", if_b.RD1, 32'h0); end
        n_vec++; if (if_b.PEND_CNT !== 6'd0) begin n_err++; $display("FAIL zero_cnt: got %0d want 0", if_b.PEND_CNT); end
        n_vec++; if (if_b.BUSY1 !== 1'b0) begin n_err++; $display("FAIL zero_nx_busy1: got %b want 0", if_b.BUSY1); end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1'b1; a3_0 = 5'd3; wd0 = 32'h10; iss = 1'b1; iss_a = 5'd3;
        step();
        idle();
        we0 = 1'b1; a3_0 = 5'd3; wd0 = 32'h20; clr0 = 1'b1; a2 = 5'd3;
        #1;
        n_vec++; if (if_b.RD2 !== 32'h20) begin n_err++; $display("FAIL byp_rd2: got %h want %h", if_b.RD2, 32'h20); end
        n_vec++; if (if_b.BUSY2 !== 1'b0) begin n_err++; $display("FAIL byp_busy2: got %b want 0", if_b.BUSY2); end
        n_vec++; if (if_n.RD2 !== 32'h10) begin n_err++; $display("FAIL nob_rd2: got %h want %h", if_n.RD2, 32'h10); end
        n_vec++; if (if_n.BUSY2 !== 1'b1) begin n_err++; $display("FAIL nob_busy2: got %b want 1", if_n.BUSY2); end
        n_vec++; if (if_b.PEND_CNT !== 6'd1) begin n_err++; $display("FAIL byp_cnt: got %0d want 1", if_b.PEND_CNT); end
        step();
        idle();
        #1;
        n_vec++; if (if_n.RD2 !== 32'h20) begin n_err++; $display("FAIL nob_nx_rd2: got %h want %h", if_n.RD2, 32'h20); end
        n_vec++; if (if_n.BUSY2 !== 1'b0) begin n_err++; $display("FAIL nob_nx_busy2: got %b want 0", if_n.BUSY2); end
        n_vec++; if (if_b.RD2 !== 32'h20) begin n_err++; $display("FAIL byp_nx_rd2: got %h want %h", if_b.RD2, 32'h20); end
        n_vec++; if (if_b.PEND_CNT !== 6'd0) begin n_err++; $display("FAIL byp_nx_cnt: got %0d want 0", if_b.PEND_CNT); end
    endtask

    task automatic test_scoreboard();
        for (int i = 1; i <= 3; i++) begin
            idle(); iss = 1'b1; iss_a = AW'(i);
            step();
            n_vec++; if (if_b.PEND_CNT !== 6'(i)) begin n_err++; $display("FAIL sb_iss%0d: got %0d want %0d", i, if_b.PEND_CNT, i); end
        end
        idle();
        we0 = 1'b1; a3_0 = 5'd2; wd0 = 32'h22; clr0 = 1'b1; iss = 1'b1; iss_a = 5'd2;
        step();
        idle(); a1 = 5'd2;
        #1;
        n_vec++; if (if_b.PEND_CNT !== 6'd3) begin n_err++; $display("FAIL sb_setclr_cnt: got %0d want 3", if_b.PEND_CNT); end
        n_vec++; if (if_b.BUSY1 !== 1'b1) begin n_err++; $display("FAIL sb_setclr_busy_b: got %b want 1", if_b.BUSY1); end
        n_vec++; if (if_n.BUSY1 !== 1'b1) begin n_err++; $display("FAIL sb_setclr_busy_n: got %b want 1", if_n.BUSY1); end
        we1 = 1'b1; a3_1 = 5'd1; wd1 = 32'h11; clr1 = 1'b1;
        step();
        idle();
        n_vec++; if (if_b.PEND_CNT !== 6'd2) begin n_err++; $display("FAIL sb_clr1_cnt: got %0d want 2", if_b.PEND_CNT); end
        we0 = 1'b1; a3_0 = 5'd3; wd0 = 32'h33; a1 = 5'd3;
        step();
        idle();
        #1;
        n_vec++; if (if_n.PEND_CNT !== 6'd2) begin n_err++; $display("FAIL sb_noclr_cnt: got %0d want 2", if_n.PEND_CNT); end
        n_vec++; if (if_n.BUSY1 !== 1'b1) begin n_err++; $display("FAIL sb_noclr_busy: got %b want 1", if_n.BUSY1); end
        we0 = 1'b1; we1 = 1'b1; a3_0 = 5'd3; a3_1 = 5'd3; clr0 = 1'b1; clr1 = 1'b1;
        step();
        idle();
        #1;
        n_vec++; if (if_b.PEND_CNT !== 6'd1) begin n_err++; $display("FAIL sb_dualclr_cnt: got %0d want 1", if_b.PEND_CNT); end
        n_vec++; if (if_b.BUSY1 !== 1'b0) begin n_err++; $display("FAIL sb_dualclr_busy: got %b want 0", if_b.BUSY1); end
        we0 = 1'b1; a3_0 = 5'd4; clr0 = 1'b1;
        step();
        idle();
        n_vec++; if (if_n.PEND_CNT !== 6'd1) begin n_err++; $display("FAIL sb_idleclr_cnt: got %0d want 1", if_n.PEND_CNT); end
    endtask

    task automatic test_fill();
        idle();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            iss = 1'b1; iss_a = AW'(i);
            step();
            n_vec++; if (if_b.PEND_CNT !== 6'(i)) begin n_err++; $display("FAIL fill_%0d: got %0d want %0d", i, if_b.PEND_CNT, i); end
        end
        iss = 1'b1; iss_a = 5'd9;
        step();
        idle(); a1 = 5'd9;
        #1;
        n_vec++; if (if_b.PEND_CNT !== 6'd31) begin n_err++; $display("FAIL fill_reiss_b: got %0d want 31", if_b.PEND_CNT); end
        n_vec++; if (if_n.PEND_CNT !== 6'd31) begin n_err++; $display("FAIL fill_reiss_n: got %0d want 31", if_n.PEND_CNT); end
        n_vec++; if (if_n.BUSY1 !== 1'b1) begin n_err++; $display("FAIL fill_busy9: got %b want 1", if_n.BUSY1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_collision();
        test_zero();
        test_bypass();
        test_scoreboard();
        test_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
